// File: rtl/cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module : cpu_bus_master
// Brief  : Host-side initiator for the CPU register bus. Turns single/burst
//          commands into timed WR/RD strobes and streams read data back.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_bus_master #(
    parameter int RD_LAT   = 1,
    parameter int ADR_STEP = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [17:0] CMD_ADR,
    input  logic [7:0]  CMD_LEN,
    input  logic        WD_VALID,
    output logic        WD_READY,
    input  logic [31:0] WD_DATA,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic [31:0] RD_DATA,
    output logic        RD_LAST,
    output logic        WR,
    output logic        RD,
    output logic [17:0] ADR,
    output logic [31:0] WDATA,
    input  logic [31:0] RDATA,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_HOLD  = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam logic [17:0] c_adr_step = 18'(ADR_STEP);
    localparam logic [2:0]  c_rd_lat   = 3'(RD_LAT);

    state_t      r_state;
    logic        r_cmd_ready;
    logic [17:0] r_cur_adr;
    logic [7:0]  r_beats;
    logic [2:0]  r_lat_cnt;
    logic        r_wr;
    logic        r_rd;
    logic [17:0] r_adr;
    logic [31:0] r_wdata;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic        r_rd_last;
    logic        r_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_cur_adr   <= '0;
            r_beats     <= '0;
            r_lat_cnt   <= '0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CMD_VALID && r_cmd_ready) begin
                        r_cur_adr   <= CMD_ADR;
                        r_beats     <= CMD_LEN;
                        r_cmd_ready <= 1'b0;
                        r_state     <= CMD_WRITE ? S_WRITE : S_RD_ISSUE;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (WD_VALID) begin
                        r_wr      <= 1'b1;
                        r_adr     <= r_cur_adr;
                        r_wdata   <= WD_DATA;
                        r_cur_adr <= r_cur_adr + c_adr_step;
                        r_beats   <= r_beats - 8'd1;
                        if (r_beats == 8'd0) begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_rd      <= 1'b1;
                    r_adr     <= r_cur_adr;
                    r_lat_cnt <= c_rd_lat;
                    r_state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Counter hits zero in the cycle RDATA is valid (RD_LAT after the RD cycle)
                    if (r_lat_cnt == 3'd0) begin
                        r_rd_data  <= RDATA;
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_beats == 8'd0);
                        r_state    <= S_RD_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                S_RD_HOLD: begin
                    if (RD_READY) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (r_beats == 8'd0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cur_adr <= r_cur_adr + c_adr_step;
                            r_beats   <= r_beats - 8'd1;
                            r_state   <= S_RD_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign WD_READY  = (r_state == S_WRITE) && !RESET;
    assign RD_VALID  = r_rd_valid;
    assign RD_DATA   = r_rd_data;
    assign RD_LAST   = r_rd_last;
    assign WR        = r_wr;
    assign RD        = r_rd;
    assign ADR       = r_adr;
    assign WDATA     = r_wdata;
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_bus_master
// Brief  : Randomized bench for cpu_bus_master with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_bus_master;

    localparam int L    = 1;
    localparam int STEP = 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0;
    logic [17:0] CMD_ADR = '0;
    logic [7:0]  CMD_LEN = '0;
    logic        WD_VALID = 1'b0;
    logic [31:0] WD_DATA = '0;
    logic        RD_READY = 1'b0;
    logic [31:0] RDATA;
    logic        CMD_READY, WD_READY, RD_VALID, RD_LAST, WR, RD, BUSY, DONE;
    logic [31:0] RD_DATA, WDATA;
    logic [17:0] ADR;

    cpu_bus_master #(.RD_LAT(L), .ADR_STEP(STEP)) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADR(CMD_ADR), .CMD_LEN(CMD_LEN),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .WR(WR), .RD(RD), .ADR(ADR), .WDATA(WDATA), .RDATA(RDATA),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Responder: returns the address as data exactly L cycles after RD, junk otherwise
    logic [17:0] rsp_adr [L];
    logic        rsp_v   [L];
    logic [17:0] junk = '0;
    always @(posedge CLK) begin
        rsp_adr[0] <= ADR;
        rsp_v[0]   <= RD;
        for (int k = 1; k < L; k++) begin
            rsp_adr[k] <= rsp_adr[k-1];
            rsp_v[k]   <= rsp_v[k-1];
        end
        junk <= 18'($urandom);
    end
    assign RDATA = rsp_v[L-1] ? {14'd0, rsp_adr[L-1]} : {14'h3FFF, junk};

    // Transaction-level model state
    logic        mon_en = 1'b0;
    logic        pend = 1'b0, m_write = 1'b0;
    logic [17:0] m_adr0 = '0;
    int          m_len = 0, acc_cyc = 0;
    int          wd_cnt = 0, wr_cnt = 0, rd_cnt = 0, hs_cnt = 0;
    int          last_wd_cyc = 0, exp_rd_cyc = 0, exp_valid_cyc = 0, exp_done_cyc = 0;
    int          last_done_cyc = -10, done_cnt = 0, wr_total = 0;
    logic [31:0] wd_q [$];
    logic        prev_reset = 1'b1, prev_rdv = 1'b0, prev_rdr = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_rdd = '0;
    logic        wd_hs_flag = 1'b0;
    // Logs for directed checks
    logic [17:0] wr_adr_log [$];
    logic [31:0] wr_dat_log [$];
    int          wr_cyc_log [$], rd_cyc_log [$], rise_log [$], hs_log [$];
    logic [31:0] rdd_log [$];
    logic        last_log [$];

    function automatic logic [17:0] beat_adr(input int i);
        return 18'((int'(m_adr0) + i * STEP) % 262144);
    endfunction

    task automatic clear_logs();
        wr_adr_log.delete(); wr_dat_log.delete(); wr_cyc_log.delete();
        rd_cyc_log.delete(); rise_log.delete(); hs_log.delete();
        rdd_log.delete(); last_log.delete();
    endtask

    task automatic mon_cycle();
        logic exp_wdr;
        check("wr_rd_excl", 32'(WR & RD), 32'd0);
        check("ready_while_busy", 32'(CMD_READY & BUSY), 32'd0);
        if (prev_reset) begin
            check("rst_wr", 32'(WR), 32'd0);
            check("rst_rd", 32'(RD), 32'd0);
            check("rst_done", 32'(DONE), 32'd0);
            check("rst_rd_valid", 32'(RD_VALID), 32'd0);
        end
        exp_wdr = pend && m_write && (cyc > acc_cyc) && (wd_cnt <= m_len) && !RESET;
        check("wd_ready", 32'(WD_READY), 32'(exp_wdr));

        if (WR) begin
            if (!pend || !m_write || wd_q.size() == 0) begin
                check("wr_unexpected", 32'(WR), 32'd0);
            end else begin
                check("wr_timing", 32'(cyc), 32'(last_wd_cyc + 1));
                check("wr_adr", 32'(ADR), 32'(beat_adr(wr_cnt)));
                check("wr_data", WDATA, wd_q.pop_front());
                wr_adr_log.push_back(ADR); wr_dat_log.push_back(WDATA); wr_cyc_log.push_back(cyc);
                wr_cnt++; wr_total++;
                if (wr_cnt == m_len + 1) exp_done_cyc = cyc + 1;
            end
        end
        wd_hs_flag = WD_VALID && WD_READY;
        if (wd_hs_flag) begin
            wd_q.push_back(WD_DATA);
            last_wd_cyc = cyc;
            wd_cnt++;
        end

        if (RD) begin
            if (!pend || m_write || rd_cnt > m_len) begin
                check("rd_unexpected", 32'(RD), 32'd0);
            end else begin
                check("rd_timing", 32'(cyc), 32'(exp_rd_cyc));
                check("rd_adr", 32'(ADR), 32'(beat_adr(rd_cnt)));
                rd_cyc_log.push_back(cyc);
                exp_valid_cyc = cyc + 1 + L;
                rd_cnt++;
            end
        end
        if (RD_VALID && !prev_rdv) begin
            if (!pend || m_write) check("rd_valid_unexpected", 32'(RD_VALID), 32'd0);
            else check("rd_valid_timing", 32'(cyc), 32'(exp_valid_cyc));
            rise_log.push_back(cyc);
        end
        if (prev_rdv && !prev_rdr) begin
            check("hold_valid", 32'(RD_VALID), 32'd1);
            check("hold_data", RD_DATA, prev_rdd);
            check("hold_last", 32'(RD_LAST), 32'(prev_last));
        end
        if (prev_rdv && prev_rdr) check("rd_valid_clear", 32'(RD_VALID), 32'd0);
        if (RD_VALID && RD_READY) begin
            if (!pend || m_write || hs_cnt >= rd_cnt) begin
                check("rd_hs_unexpected", 32'(RD_VALID), 32'd0);
            end else begin
                check("rd_data", RD_DATA, {14'd0, beat_adr(hs_cnt)});
                check("rd_last", 32'(RD_LAST), 32'(hs_cnt == m_len));
                rdd_log.push_back(RD_DATA); last_log.push_back(RD_LAST); hs_log.push_back(cyc);
                hs_cnt++;
                if (hs_cnt == m_len + 1) exp_done_cyc = cyc + 2;
                else exp_rd_cyc = cyc + 2;
            end
        end

        if (DONE) begin
            if (!pend) begin
                check("done_unexpected", 32'(DONE), 32'd0);
            end else begin
                check("done_timing", 32'(cyc), 32'(exp_done_cyc));
                check("done_beats", 32'(m_write ? wr_cnt : hs_cnt), 32'(m_len + 1));
            end
            pend = 1'b0;
            last_done_cyc = cyc;
            done_cnt++;
        end
        check("busy", 32'(BUSY), 32'(pend && cyc > acc_cyc));
        check("cmd_ready", 32'(CMD_READY), 32'(!pend && cyc != last_done_cyc));

        if (CMD_VALID && CMD_READY && !RESET) begin
            pend = 1'b1; m_write = CMD_WRITE; m_adr0 = CMD_ADR; m_len = int'(CMD_LEN);
            acc_cyc = cyc; exp_rd_cyc = cyc + 2;
            wd_cnt = 0; wr_cnt = 0; rd_cnt = 0; hs_cnt = 0;
            wd_q.delete();
        end
        if (RESET) begin
            pend = 1'b0;
            wd_q.delete();
        end
        prev_reset = RESET; prev_rdv = RD_VALID; prev_rdr = RD_READY;
        prev_rdd = RD_DATA; prev_last = RD_LAST;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) mon_cycle();
        end
    end

    // Background drivers for the data streams; modes chosen per test
    int          wd_mode = 0, rd_mode = 0, data_mode = 0, rdv_hold = 0;
    logic [31:0] wd_seq = 32'd1, wd_fixed = '0;
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (wd_hs_flag) wd_seq++;
            case (wd_mode)
                0:       WD_VALID = 1'b1;
                1:       WD_VALID = ~WD_VALID;
                default: WD_VALID = 1'($urandom_range(0, 1));
            endcase
            case (data_mode)
                0:       WD_DATA = $urandom;
                1:       WD_DATA = wd_seq;
                default: WD_DATA = wd_fixed;
            endcase
            rdv_hold = RD_VALID ? rdv_hold + 1 : 0;
            case (rd_mode)
                0:       RD_READY = 1'b1;
                1:       RD_READY = (rdv_hold > 5);
                default: RD_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_cmd(input logic w, input logic [17:0] a, input logic [7:0] len);
        int k = 0;
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADR = a; CMD_LEN = len;
        @(negedge CLK);
        while (!CMD_READY && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (!CMD_READY) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0; CMD_WRITE = 1'($urandom); CMD_ADR = 18'($urandom); CMD_LEN = 8'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < 5000) begin
            @(posedge CLK); #1;
            k++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        int lens [4];
        // Reset values
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_wr", 32'(WR), 32'd0);
        check("reset_rd", 32'(RD), 32'd0);
        check("reset_rd_valid", 32'(RD_VALID), 32'd0);
        check("reset_rd_last", 32'(RD_LAST), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_adr", 32'(ADR), 32'd0);
        check("reset_wdata", WDATA, 32'd0);
        check("reset_rd_data", RD_DATA, 32'd0);
        check("reset_cmd_ready", 32'(CMD_READY), 32'd1);
        check("reset_wd_ready", 32'(WD_READY), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;

        // Single write
        clear_logs(); wd_mode = 0; data_mode = 2; wd_fixed = 32'hDEADBEEF;
        send_cmd(1'b1, 18'h00010, 8'd0);
        wait_done();
        check("t1_wr_count", 32'(wr_adr_log.size()), 32'd1);
        if (wr_adr_log.size() == 1) begin
            check("t1_adr", 32'(wr_adr_log[0]), 32'h00010);
            check("t1_data", wr_dat_log[0], 32'hDEADBEEF);
            check("t1_wr_latency", 32'(wr_cyc_log[0] - acc_cyc), 32'd2);
        end
        check("t1_done_latency", 32'(last_done_cyc - acc_cyc), 32'd3);
        repeat (2) @(posedge CLK); #1;

        // Write burst with gaps across the address wrap
        clear_logs(); wd_mode = 1; data_mode = 1; wd_seq = 32'd1;
        send_cmd(1'b1, 18'h3FFFE, 8'd3);
        wait_done();
        check("t2_wr_count", 32'(wr_adr_log.size()), 32'd4);
        if (wr_adr_log.size() == 4) begin
            check("t2_adr0", 32'(wr_adr_log[0]), 32'h3FFFE);
            check("t2_adr1", 32'(wr_adr_log[1]), 32'h3FFFF);
            check("t2_adr2", 32'(wr_adr_log[2]), 32'h00000);
            check("t2_adr3", 32'(wr_adr_log[3]), 32'h00001);
            for (int i = 0; i < 4; i++) check("t2_data", wr_dat_log[i], 32'(i + 1));
            for (int i = 1; i < 4; i++) check("t2_gap", 32'(wr_cyc_log[i] - wr_cyc_log[i-1]), 32'd2);
        end
        repeat (2) @(posedge CLK); #1;

        // Read burst, ready tied high
        clear_logs(); rd_mode = 0; data_mode = 0; wd_mode = 2;
        send_cmd(1'b0, 18'h00000, 8'd9);
        wait_done();
        check("t3_beats", 32'(rdd_log.size()), 32'd10);
        if (rdd_log.size() == 10 && rd_cyc_log.size() == 10 && rise_log.size() == 10) begin
            check("t3_rd_latency", 32'(rd_cyc_log[0] - acc_cyc), 32'd2);
            check("t3_valid_latency", 32'(rise_log[0] - acc_cyc), 32'(3 + L));
            for (int i = 0; i < 10; i++) check("t3_data", rdd_log[i], 32'(i));
            for (int i = 0; i < 10; i++) check("t3_last", 32'(last_log[i]), 32'(i == 9));
            for (int i = 1; i < 10; i++) check("t3_period", 32'(rd_cyc_log[i] - rd_cyc_log[i-1]), 32'(L + 3));
        end
        repeat (2) @(posedge CLK); #1;

        // Read backpressure: ready held low for 5 valid cycles
        clear_logs(); rd_mode = 1;
        send_cmd(1'b0, 18'h01234, 8'd2);
        wait_done();
        check("t4_beats", 32'(hs_log.size()), 32'd3);
        if (hs_log.size() == 3 && rise_log.size() == 3 && rd_cyc_log.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t4_stall", 32'(hs_log[i] - rise_log[i]), 32'd5);
            for (int i = 1; i < 3; i++) check("t4_period", 32'(rd_cyc_log[i] - rd_cyc_log[i-1]), 32'(L + 8));
        end
        repeat (2) @(posedge CLK); #1;

        // Reset in the middle of a write burst
        begin
            int k = 0;
            int d0;
            clear_logs(); wd_mode = 0; rd_mode = 0;
            send_cmd(1'b1, 18'h00100, 8'd7);
            while (wr_adr_log.size() < 2 && k < 50) begin
                @(negedge CLK);
                k++;
            end
            check("t5_two_writes", 32'(wr_adr_log.size() >= 2), 32'd1);
            d0 = done_cnt;
            @(posedge CLK); #1; RESET = 1'b1;
            @(posedge CLK); #1; RESET = 1'b0;
            repeat (5) @(posedge CLK);
            @(negedge CLK);
            check("t5_no_done", 32'(done_cnt), 32'(d0));
            check("t5_cmd_ready", 32'(CMD_READY), 32'd1);
            check("t5_wr_low", 32'(WR), 32'd0);
            @(posedge CLK); #1;
            clear_logs();
            send_cmd(1'b0, 18'h00055, 8'd0);
            wait_done();
            check("t5_read_beats", 32'(rdd_log.size()), 32'd1);
            if (rdd_log.size() == 1) check("t5_read_data", rdd_log[0], 32'h00055);
        end
        repeat (2) @(posedge CLK); #1;

        // Randomized commands
        lens = '{0, 3, 15, 255};
        for (int n = 0; n < 40; n++) begin
            logic [17:0] a;
            logic [7:0]  len;
            wd_mode = $urandom_range(0, 2);
            rd_mode = ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 2);
            data_mode = 0;
            a = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFF8 + $urandom_range(0, 7)) : 18'($urandom);
            len = (n % 20 == 19) ? 8'(lens[3]) : 8'($urandom_range(0, lens[$urandom_range(0, 2)]));
            send_cmd(1'($urandom_range(0, 1)), a, len);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end

        repeat (4) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
